// File: rtl/dm_sized_port.sv
// ---------------------------------------------------------------------------
// dm_sized_port
//   Data-memory port for the pipelined MIPS core. Supports byte, halfword and
//   word loads/stores with sign or zero extension, a valid/ready request
//   handshake, WAIT extra wait states per access and a one-cycle response.
//
// Parameters
//   ADDR_W : byte-address bits decoded; array holds 2^(ADDR_W-2) 32-bit words
//   WAIT   : extra wait cycles per access (0..15)
//   TRACE  : 1 = print a trace line for every committed store
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        zero-extend sub-word loads
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   req_pc              instruction PC, used only by the trace line
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            access rejected (qualified by resp_valid)
//   busy                an accepted access has not yet responded
// ---------------------------------------------------------------------------
module dm_sized_port #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 0,
    parameter bit TRACE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAITING, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;

    // Request fields captured at acceptance.
    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;

    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_exec;
    logic              w_err;
    logic [ADDR_W-3:0] w_idx;
    logic [31:0]       w_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign req_ready  = (r_state != S_WAITING);
    assign busy       = (r_state == S_WAITING);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept = req_valid && req_ready;
    assign w_exec   = (r_state == S_WAITING) && (r_cnt == 4'd0);

    assign w_err = (r_size == 2'b11)
                || (r_size == 2'b01 && r_addr[0])
                || (r_size == 2'b10 && r_addr[1:0] != 2'b00)
                || (r_addr[31:ADDR_W] != '0);

    assign w_idx  = r_addr[ADDR_W-1:2];
    assign w_word = r_mem[w_idx];

    // Lane merge for stores and lane extract/extend for loads.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_merged = w_word;
        w_load   = w_word;
        w_byte   = w_word[{r_addr[1:0], 3'b000} +: 8];
        w_half   = w_word[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00: begin
                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
                w_load = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
                w_load = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            2'b10: begin
                w_merged = r_wdata;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_WAITING;
            S_WAITING: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:    w_next = w_accept ? S_WAITING : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            // NOTE: the array is cleared by reset, so it is built from
            // registers rather than a RAM macro without a clear port.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_pc       <= req_pc;
                r_cnt      <= WAIT_CNT;
            end else if (r_state == S_WAITING && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Response registers are loaded only on the executing edge, so
            // they are nonzero only during the RESP cycle.
            if (w_exec) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                if (!w_err && r_we) begin
                    r_mem[w_idx] <= w_merged;
                end
            end else begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    generate
        if (TRACE) begin : g_trace
            always_ff @(posedge clk) begin
                if (!reset && w_exec && !w_err && r_we) begin
                    $display("%d@%h: *%h <= %h", $time, r_pc,
                             {r_addr[31:2], 2'b00}, w_merged);
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_dm_sized_port.sv
// ---------------------------------------------------------------------------
// tb_dm_sized_port
//   Bench for dm_sized_port. Two instances share clock, reset and request
//   fields: dut0 with WAIT = 0 and dut3 with WAIT = 3. Expected data come from
//   a byte-addressed little-endian memory model.
// ---------------------------------------------------------------------------
module tb_dm_sized_port;

    localparam int ADDR_W = 12;

    logic        clk;
    logic        reset;
    logic        v0, v3;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, pc;

    logic        ready0, rv0, err0, busy0;
    logic [31:0] rdata0;
    logic        ready3, rv3, err3, busy3;
    logic [31:0] rdata3;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m [4096];

    dm_sized_port #(.ADDR_W(ADDR_W), .WAIT(0), .TRACE(1)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(ready0),
        .req_we(we), .req_size(size), .req_unsigned(uns),
        .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
        .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0), .busy(busy0)
    );

    dm_sized_port #(.ADDR_W(ADDR_W), .WAIT(3), .TRACE(1)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(v3), .req_ready(ready3),
        .req_we(we), .req_size(size), .req_unsigned(uns),
        .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
        .resp_valid(rv3), .resp_rdata(rdata3), .resp_err(err3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) m[i] = 8'h00;
    endtask

    // Reference behaviour: byte-granular memory, size in bytes, arithmetic
    // alignment and range checks.
    task automatic model(input logic mwe, input logic [1:0] msize, input logic muns,
                         input logic [31:0] maddr, input logic [31:0] mwdata,
                         output logic [31:0] rd, output logic e);
        int n;
        logic [31:0] val;
        n   = (msize == 2'd0) ? 1 : (msize == 2'd1) ? 2 : 4;
        e   = (msize == 2'd3) || ((maddr % n) != 0) || (maddr >= (32'd1 << ADDR_W));
        rd  = 32'd0;
        val = 32'd0;
        if (!e) begin
            if (mwe) begin
                for (int k = 0; k < n; k++) m[maddr[11:0] + 12'(k)] = mwdata[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) val = val | (32'(m[maddr[11:0] + 12'(k)]) << (8*k));
                if (n < 4 && !muns && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                rd = val;
            end
        end
    endtask

    // One access issued to both instances; checks pulse timing, busy and data.
    task automatic access(input logic awe, input logic [1:0] asize, input logic auns,
                          input logic [31:0] aaddr, input logic [31:0] awdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        model(awe, asize, auns, aaddr, awdata, exp_rd, exp_err);
        @(negedge clk);
        check("ready0_idle", {31'b0, ready0}, 32'd1);
        check("ready3_idle", {31'b0, ready3}, 32'd1);
        we = awe; size = asize; uns = auns; addr = aaddr; wdata = awdata;
        pc = $urandom;
        v0 = 1'b1; v3 = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            v0 = 1'b0; v3 = 1'b0;
            check("resp_valid0", {31'b0, rv0}, {31'b0, (j == 1)});
            check("busy0", {31'b0, busy0}, {31'b0, (j < 1)});
            check("resp_valid3", {31'b0, rv3}, {31'b0, (j == 4)});
            check("busy3", {31'b0, busy3}, {31'b0, (j < 4)});
            if (j == 1) begin
                check("rdata0", rdata0, exp_rd);
                check("err0", {31'b0, err0}, {31'b0, exp_err});
            end
            if (j == 4) begin
                check("rdata3", rdata3, exp_rd);
                check("err3", {31'b0, err3}, {31'b0, exp_err});
            end
            if (j == 2) check("rdata3_wait", rdata3, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] r;

        reset = 1'b1; v0 = 1'b0; v3 = 1'b0;
        we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0; pc = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready0", {31'b0, ready0}, 32'd1);
        check("rst_ready3", {31'b0, ready3}, 32'd1);
        check("rst_rv0", {31'b0, rv0}, 32'd0);
        check("rst_busy3", {31'b0, busy3}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_err3", {31'b0, err3}, 32'd0);

        // Word store / load.
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        // Byte lane 3.
        access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        // Upper half lane.
        access(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001);
        access(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        // Rejected accesses leave the array alone.
        access(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
        access(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF_FFFF);
        access(1'b1, 2'd2, 1'b0, 32'h1000, 32'hFFFF_FFFF);
        access(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

        // Randomised mix over a small window plus out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rs;
            logic [31:0] ra;
            r  = $urandom % 8;
            rs = (r < 7) ? 2'(r % 3) : 2'd3;
            ra = (($urandom % 16) == 0) ? 32'h1000 + ($urandom % 64) : ($urandom % 64);
            access(1'($urandom % 2), rs, 1'($urandom % 2), ra, $urandom);
        end

        // Back-to-back loads held valid on the WAIT = 3 instance.
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, exp_rd, exp_err);
        @(negedge clk);
        we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h10;
        check("b2b_ready_idle", {31'b0, ready3}, 32'd1);
        v3 = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            check("b2b_ready", {31'b0, ready3}, {31'b0, (j % 5 == 4)});
            check("b2b_resp_valid", {31'b0, rv3}, {31'b0, (j % 5 == 4)});
            check("b2b_busy", {31'b0, busy3}, {31'b0, (j % 5 != 4)});
            if (j % 5 == 4) check("b2b_rdata", rdata3, exp_rd);
        end
        v3 = 1'b0;
        @(negedge clk);
        check("b2b_end_busy", {31'b0, busy3}, 32'd0);
        check("b2b_end_ready", {31'b0, ready3}, 32'd1);
        check("b2b_end_rv", {31'b0, rv3}, 32'd0);

        // Reset two cycles after accepting a store aborts it on dut3.
        @(negedge clk);
        we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h30; wdata = 32'hDEAD_BEEF;
        v0 = 1'b1; v3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v3 = 1'b0;
        check("abort_busy", {31'b0, busy3}, 32'd1);
        @(negedge clk);
        check("abort_rv_pre", {31'b0, rv3}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("abort_ready", {31'b0, ready3}, 32'd1);
        check("abort_busy_after", {31'b0, busy3}, 32'd0);
        check("abort_rdata", rdata3, 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("abort_no_resp", {31'b0, rv3}, 32'd0);
        end
        access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
